// File: rtl/evb_operand_store.sv
// Read responder for the evaluation block: circular x-value buffer plus a
// coefficient RAM (S) and degree register file (N), each with one-cycle reads.
module evb_operand_store #(
  parameter int unsigned buffer_size = 1024,
  localparam int unsigned AW = $clog2(buffer_size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          release_en,
  input  logic [AW:0]   release_cnt,
  input  logic          en_rd_data,
  input  logic [AW-1:0] rd_addr_data,
  output logic [15:0]   x_out,
  output logic          x_valid,
  output logic          rd_err,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          wr_err,
  input  logic          wr_en_S,
  input  logic [7:0]    wr_addr_S,
  input  logic [15:0]   wr_data_S,
  input  logic          en_rd_S,
  input  logic [7:0]    rd_addr_S,
  output logic [15:0]   S_out,
  input  logic          wr_en_N,
  input  logic [2:0]    wr_A,
  input  logic [4:0]    wr_N,
  input  logic          en_rd_N,
  input  logic [2:0]    A,
  output logic [4:0]    N_out
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(buffer_size);

  logic [15:0]   xmem [buffer_size];
  logic [15:0]   smem [256];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   x_out_q, x_out_d;
  logic          x_valid_q, x_valid_d;
  logic          rd_err_q, rd_err_d;
  logic          wr_err_q, wr_err_d;
  logic [15:0]   s_out_q;
  logic [4:0]    n_out_q;
  logic [4:0]    nreg_q [8];

  logic          full_w;
  logic          wr_acc;
  logic          rd_ok;
  logic [AW:0]   rel;
  logic [AW-1:0] rd_ptr;

  assign full_w = (count_q == FULL_CNT);
  assign wr_acc = wr_en && !full_w && !clr;
  assign rd_ok  = ({1'b0, rd_addr_data} < count_q);
  assign rd_ptr = head_q + rd_addr_data;

  always_comb begin
    rel = '0;
    if (release_en) begin
      rel = (release_cnt > count_q) ? count_q : release_cnt;
    end
  end

  // Reads see pre-update head/count; clr wins over same-cycle write/release.
  always_comb begin
    head_d    = head_q + rel[AW-1:0];
    tail_d    = tail_q + AW'(wr_acc);
    count_d   = count_q + {{AW{1'b0}}, wr_acc} - rel;
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
    wr_err_d  = wr_en && full_w;
    x_valid_d = en_rd_data && rd_ok;
    rd_err_d  = en_rd_data && !rd_ok;
    x_out_d   = x_out_q;
    if (en_rd_data) begin
      x_out_d = rd_ok ? xmem[rd_ptr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      rd_err_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      rd_err_q  <= rd_err_d;
      wr_err_q  <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      xmem[tail_q] <= wr_data;
    end
    if (wr_en_S) begin
      smem[wr_addr_S] <= wr_data_S;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_out_q <= '0;
      n_out_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        nreg_q[i] <= '0;
      end
    end else begin
      if (en_rd_S) begin
        s_out_q <= smem[rd_addr_S];
      end
      if (en_rd_N) begin
        n_out_q <= nreg_q[A];
      end
      if (wr_en_N) begin
        nreg_q[wr_A] <= wr_N;
      end
    end
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign rd_err  = rd_err_q;
  assign wr_err  = wr_err_q;
  assign count   = count_q;
  assign full    = full_w;
  assign empty   = (count_q == '0);
  assign S_out   = s_out_q;
  assign N_out   = n_out_q;

endmodule

// File: tb/tb_evb_operand_store.sv
// Directed bench for evb_operand_store with a 4-word x-buffer so full and
// pointer wrap are reached quickly.
module tb_evb_operand_store;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        release_en;
  logic [2:0]  release_cnt;
  logic        en_rd_data;
  logic [1:0]  rd_addr_data;
  logic [15:0] x_out;
  logic        x_valid;
  logic        rd_err;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        wr_err;
  logic        wr_en_S;
  logic [7:0]  wr_addr_S;
  logic [15:0] wr_data_S;
  logic        en_rd_S;
  logic [7:0]  rd_addr_S;
  logic [15:0] S_out;
  logic        wr_en_N;
  logic [2:0]  wr_A;
  logic [4:0]  wr_N;
  logic        en_rd_N;
  logic [2:0]  A;
  logic [4:0]  N_out;

  int unsigned passed = 0;
  int unsigned total  = 0;

  evb_operand_store #(.buffer_size(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data),
    .release_en(release_en), .release_cnt(release_cnt),
    .en_rd_data(en_rd_data), .rd_addr_data(rd_addr_data),
    .x_out(x_out), .x_valid(x_valid), .rd_err(rd_err),
    .count(count), .full(full), .empty(empty), .wr_err(wr_err),
    .wr_en_S(wr_en_S), .wr_addr_S(wr_addr_S), .wr_data_S(wr_data_S),
    .en_rd_S(en_rd_S), .rd_addr_S(rd_addr_S), .S_out(S_out),
    .wr_en_N(wr_en_N), .wr_A(wr_A), .wr_N(wr_N),
    .en_rd_N(en_rd_N), .A(A), .N_out(N_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; wr_data = '0; release_en = 0; release_cnt = '0;
    en_rd_data = 0; rd_addr_data = '0;
    wr_en_S = 0; wr_addr_S = '0; wr_data_S = '0; en_rd_S = 0; rd_addr_S = '0;
    wr_en_N = 0; wr_A = '0; wr_N = '0; en_rd_N = 0; A = '0;
  endtask

  // Apply the currently driven inputs at one rising edge, then return them to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr_x(input logic [15:0] d);
    wr_en = 1; wr_data = d; tick();
  endtask

  task automatic rd_x(input logic [1:0] off);
    en_rd_data = 1; rd_addr_data = off; tick();
  endtask

  task automatic rel_x(input logic [2:0] n);
    release_en = 1; release_cnt = n; tick();
  endtask

  initial begin
    idle();
    rst = 0;
    #12;
    chk("rst_x_out", x_out, 0);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_S_out", S_out, 0);
    chk("rst_N_out", N_out, 0);
    rst = 1;
    @(posedge clk); #1;

    wr_x(16'h0011); wr_x(16'h0022); wr_x(16'h0033);
    chk("count3", count, 3);
    chk("empty_after_wr", empty, 0);
    rd_x(2'd0);
    chk("rd0_data", x_out, 16'h0011);
    chk("rd0_valid", x_valid, 1);
    rd_x(2'd2);
    chk("rd2_data", x_out, 16'h0033);
    chk("rd2_valid", x_valid, 1);
    tick();
    chk("x_valid_pulse", x_valid, 0);
    chk("x_out_hold", x_out, 16'h0033);

    wr_x(16'h0044);
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    wr_x(16'h0055);
    chk("wr_err_pulse", wr_err, 1);
    chk("count_after_drop", count, 4);
    tick();
    chk("wr_err_clear", wr_err, 0);

    rel_x(3'd2);
    chk("count_rel2", count, 2);
    chk("full_clear", full, 0);
    wr_x(16'h0066); wr_x(16'h0077);
    chk("count_refill", count, 4);
    rd_x(2'd3);
    chk("wrap_rd3", x_out, 16'h0077);
    rd_x(2'd0);
    chk("wrap_rd0", x_out, 16'h0033);

    rel_x(3'd3);
    chk("count_one", count, 1);
    rd_x(2'd1);
    chk("oob_rd_err", rd_err, 1);
    chk("oob_x_out", x_out, 0);
    chk("oob_x_valid", x_valid, 0);
    rd_x(2'd0);
    chk("last_word", x_out, 16'h0077);
    chk("rd_err_clear", rd_err, 0);
    rel_x(3'd5);
    chk("over_release_count", count, 0);
    chk("over_release_empty", empty, 1);

    wr_x(16'h00A1); wr_x(16'h00A2);
    chk("count_two", count, 2);
    wr_en = 1; wr_data = 16'h00A3; release_en = 1; release_cnt = 3'd1;
    en_rd_data = 1; rd_addr_data = 2'd0;
    tick();
    chk("wr_rel_count", count, 2);
    chk("same_cycle_rd", x_out, 16'h00A1);
    rd_x(2'd1);
    chk("after_wr_rel_rd1", x_out, 16'h00A3);
    clr = 1; en_rd_data = 1; rd_addr_data = 2'd0; wr_en = 1; wr_data = 16'h00B0;
    tick();
    chk("clr_rd_preclear", x_out, 16'h00A2);
    chk("clr_rd_valid", x_valid, 1);
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);

    wr_en_S = 1; wr_addr_S = 8'h7F; wr_data_S = 16'hBEEF; tick();
    en_rd_S = 1; rd_addr_S = 8'h7F; tick();
    chk("S_read", S_out, 16'hBEEF);
    wr_en_S = 1; wr_addr_S = 8'h7F; wr_data_S = 16'h1234;
    en_rd_S = 1; rd_addr_S = 8'h7F; tick();
    chk("S_rbw_old", S_out, 16'hBEEF);
    en_rd_S = 1; rd_addr_S = 8'h7F; tick();
    chk("S_rbw_new", S_out, 16'h1234);
    tick();
    chk("S_hold", S_out, 16'h1234);

    wr_en_N = 1; wr_A = 3'd5; wr_N = 5'd17; tick();
    en_rd_N = 1; A = 3'd5; tick();
    chk("N_read", N_out, 17);
    wr_en_N = 1; wr_A = 3'd5; wr_N = 5'd3; en_rd_N = 1; A = 3'd5; tick();
    chk("N_rbw_old", N_out, 17);
    en_rd_N = 1; A = 3'd4; tick();
    chk("N_other_idx", N_out, 0);
    en_rd_N = 1; A = 3'd5; tick();
    chk("N_rbw_new", N_out, 3);

    wr_x(16'h00C1);
    rd_x(2'd0);
    chk("pre_rst_x", x_out, 16'h00C1);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_x_out", x_out, 0);
    chk("mid_rst_x_valid", x_valid, 0);
    chk("mid_rst_S_out", S_out, 0);
    chk("mid_rst_N_out", N_out, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    en_rd_N = 1; A = 3'd5; tick();
    chk("post_rst_Nreg", N_out, 0);
    rd_x(2'd0);
    chk("post_rst_rd_err", rd_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
